// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (idle / burst in progress)
//   STAT_W      : width of the optional per-requester word counters
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search. Starting just after 'last', the first
// set bit of 'req' (wrapping modulo N) is returned as 'winner'.
//   req    [N]   : request vector
//   last   [IDW] : index granted most recently
//   winner [IDW] : selected index (0 when nothing is requested)
//   any    [1]   : at least one request is set
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] winner,
    output logic           any
);

    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        // k runs 1..N so 'last' itself is the lowest-priority candidate
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx[IDW-1:0]]) begin
                any    = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ
// producers. A grant lasts up to MAX_BURST words, ends early when the owner
// goes idle, and never writes while wr_full is high.
//   clk, rst_n        : FIFO write clock, async active-low reset
//   req_valid/ready   : per-requester handshake (NUM_REQ)
//   req_data          : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_en/wr_data     : FIFO write port; wr_full : FIFO full flag
//   grant_valid/id    : registered grant status (id = current/last owner)
// Optional build macro FIFO_ARB_STATS_EN adds stat_sel/stat_clr/stat_count:
// saturating 16-bit accepted-word counters, one per requester.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_BITS    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_full,
`ifdef FIFO_ARB_STATS_EN
    input  logic [ID_BITS-1:0]            stat_sel,
    input  logic                          stat_clr,
    output logic [STAT_W-1:0]             stat_count,
`endif
    output logic                          grant_valid,
    output logic [ID_BITS-1:0]            grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state, state_nxt;
    logic [ID_BITS-1:0] owner, owner_nxt;
    logic [ID_BITS-1:0] last_owner, last_nxt;
    logic [CNT_W-1:0]   burst_cnt, cnt_nxt;
    logic [ID_BITS-1:0] pick_id;
    logic               pick_any;
    logic               owner_valid;
    logic               xfer;

    rr_pick #(.N(NUM_REQ), .IDW(ID_BITS)) u_pick (
        .req    (req_valid),
        .last   (last_owner),
        .winner (pick_id),
        .any    (pick_any)
    );

    assign owner_valid = req_valid[owner];
    assign xfer        = (state == ARB_BURST) && owner_valid && !wr_full;

    // State register; grant status is registered from the next-state values
    // so it lines up with the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            owner       <= '0;
            last_owner  <= ID_BITS'(NUM_REQ - 1);
            burst_cnt   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_nxt;
            burst_cnt   <= cnt_nxt;
            grant_valid <= (state_nxt == ARB_BURST);
            grant_id    <= owner_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
        cnt_nxt   = burst_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    owner_nxt = pick_id;
                    cnt_nxt   = '0;
                    state_nxt = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (xfer) begin
                    cnt_nxt = burst_cnt + 1'b1;
                    if (cnt_nxt == CNT_W'(MAX_BURST)) begin
                        state_nxt = ARB_IDLE;
                        last_nxt  = owner;
                    end
                end else if (!wr_full && !owner_valid) begin
                    // owner went idle; a drop while full does not end the grant
                    state_nxt = ARB_IDLE;
                    last_nxt  = owner;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs: ready depends only on state and wr_full, never on req_valid
    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        if (state == ARB_BURST) begin
            req_ready[owner] = !wr_full;
            wr_en            = owner_valid && !wr_full;
            wr_data          = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (stat_clr) begin
            stat_cnt <= '0;
        end else if (xfer && (stat_cnt[owner] != '1)) begin
            stat_cnt[owner] <= stat_cnt[owner] + 1'b1;
        end
    end

    assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            wr_full;
    logic            grant_valid;
    logic [1:0]      grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [1:0]      stat_sel;
    logic            stat_clr;
    logic [15:0]     stat_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] mem[N][16];
    int            head[N];
    int            tail[N];

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
`ifdef FIFO_ARB_STATS_EN
        .stat_sel    (stat_sel),
        .stat_clr    (stat_clr),
        .stat_count  (stat_count),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (head[i] < tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = head[i] < tail[i];
            req_data[i*DW +: DW]  = (head[i] < tail[i]) ? mem[i][head[i]] : 8'h00;
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic load(input int id, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            mem[id][tail[id]] = base + DW'(k);
            tail[id]++;
        end
    endtask

    task automatic expect_words(input int id, input int n, input logic [DW-1:0] base);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = 2'(id);
            e.data = base + DW'(k);
            exp_q.push_back(e);
        end
    endtask

    // One clock: record handshakes mid-cycle, advance the requester queues
    // just after the edge and re-drive.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) head[i]++;
        drive();
    endtask

    task automatic run_until_idle(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(all_empty() && !grant_valid) && n < max);
    endtask

    // Monitor: every accepted FIFO write must be the next expected word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {grant_id, wr_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", wr_data, e.data);
                    chk("grant_id_on_write", grant_id, e.id);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected to");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        wr_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_sel = 2'd0;
        stat_clr = 1'b0;
`endif
        clear_q();
        load(0, 1, 8'h55);
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        clear_q();
        drive();
        rst_n = 1'b1;
        tick();

        // all requesting: order 0,1,2,3,0, four words each, one idle gap
        clear_q();
        load(0, 8, 8'h00);
        load(1, 4, 8'h10);
        load(2, 4, 8'h20);
        load(3, 4, 8'h30);
        expect_words(0, 4, 8'h00);
        expect_words(1, 4, 8'h10);
        expect_words(2, 4, 8'h20);
        expect_words(3, 4, 8'h30);
        expect_words(0, 4, 8'h04);
        drive();
        n = 0;
        do begin
            tick();
            n++;
        end while (!all_empty() && n < 100);
        chk("rr_cycles", n, 25);
        chk("rr_idle_after", grant_valid, 0);

        // single streaming requester: bursts 4,4,2
        clear_q();
        load(2, 10, 8'hA0);
        expect_words(2, 10, 8'hA0);
        drive();
        n = 0;
        do begin
            tick();
            n++;
        end while (!all_empty() && n < 100);
        chk("stream_cycles", n, 13);
        chk("stream_grant_held", grant_valid, 1);
        tick();
        chk("stream_exit", grant_valid, 0);
        chk("stream_grant_id", grant_id, 2);

        // wr_full mid-burst after two words
        clear_q();
        load(3, 4, 8'h30);
        expect_words(3, 4, 8'h30);
        drive();
        repeat (3) tick();
        chk("full_words_before", head[3], 2);
        wr_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("full_wr_en", wr_en, 0);
            chk("full_req_ready", req_ready, 0);
            chk("full_grant_valid", grant_valid, 1);
            chk("full_grant_id", grant_id, 3);
            tick();
        end
        wr_full = 1'b0;
        repeat (2) tick();
        chk("full_words_after", head[3], 4);
        chk("full_exit", grant_valid, 0);

        // requester 1 goes idle after one word; grant passes to 3
        clear_q();
        load(1, 1, 8'h11);
        load(3, 2, 8'h35);
        expect_words(1, 1, 8'h11);
        expect_words(3, 2, 8'h35);
        drive();
        run_until_idle(50, n);
        chk("drop_cycles", n, 7);

        // reset in the middle of requester 2's burst
        clear_q();
        load(2, 4, 8'h2C);
        expect_words(2, 2, 8'h2C);
        drive();
        repeat (3) tick();
        chk("pre_rst_grant_id", grant_id, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_grant_valid", grant_valid, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        @(posedge clk);
        #1;
        clear_q();
        load(0, 1, 8'hC0);
        load(1, 1, 8'hC1);
        load(2, 1, 8'hC2);
        load(3, 1, 8'hC3);
        expect_words(0, 1, 8'hC0);
        expect_words(1, 1, 8'hC1);
        expect_words(2, 1, 8'hC2);
        expect_words(3, 1, 8'hC3);
        drive();
        rst_n = 1'b1;
        tick();
        chk("post_rst_first_grant", grant_id, 0);
        run_until_idle(50, n);
        chk("post_rst_cycles", n, 11);

`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        clear_q();
        load(3, 3, 8'h70);
        expect_words(3, 3, 8'h70);
        drive();
        run_until_idle(50, n);
        stat_sel = 2'd3;
        #1;
        chk("stat_count3", stat_count, 3);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        chk("stat_clr", stat_count, 0);
        force dut.stat_cnt = 64'h0000_0000_FFFF_0000;
        @(posedge clk);
        #1;
        release dut.stat_cnt;
        clear_q();
        load(1, 2, 8'h90);
        expect_words(1, 2, 8'h90);
        drive();
        run_until_idle(50, n);
        stat_sel = 2'd1;
        #1;
        chk("stat_saturate", stat_count, 16'hFFFF);
`endif

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
